// File: rtl/psk_demod_packer.sv
// rtl/psk_demod_packer.sv - BPSK/QPSK hard-decision detector with MSB-first word packer
//
// Makes a hard BPSK or QPSK decision on each signed I/Q symbol and packs the
// decided bits MSB-first into OUT_WIDTH-bit words. Each word carries a sticky
// low-confidence flag. A flush request emits a partial word.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   mode                0 = BPSK, 1 = QPSK (latched at the first symbol of a word)
//   thresh              unsigned confidence threshold
//   flush               emit the current partial word (honoured while s_tready=1)
//   s_i_tdata/s_q_tdata signed I/Q sample; s_tvalid/s_tready input handshake
//   m_tdata             packed bits, first symbol in the MSBs
//   m_nbits             number of valid bits in m_tdata
//   m_tlast             word was produced by a flush
//   m_low_conf          some symbol in the word fell below thresh
//   m_tvalid/m_tready   output handshake
module psk_demod_packer #(
  parameter int WIDTH     = 16,
  parameter int OUT_WIDTH = 8,
  parameter int CNT_W     = $clog2(OUT_WIDTH + 1)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 mode,
  input  logic [WIDTH-1:0]     thresh,
  input  logic                 flush,
  input  logic [WIDTH-1:0]     s_i_tdata,
  input  logic [WIDTH-1:0]     s_q_tdata,
  input  logic                 s_tvalid,
  output logic                 s_tready,
  output logic [OUT_WIDTH-1:0] m_tdata,
  output logic [CNT_W-1:0]     m_nbits,
  output logic                 m_tlast,
  output logic                 m_low_conf,
  output logic                 m_tvalid,
  input  logic                 m_tready
);

  typedef enum logic {EMPTY = 1'b0, PARTIAL = 1'b1} state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     fill_q, fill_d;
  logic [OUT_WIDTH-1:0] acc_q, acc_d;
  logic                 sticky_q, sticky_d;
  logic                 mode_q, mode_d;
  logic [OUT_WIDTH-1:0] m_tdata_q, m_tdata_d;
  logic [CNT_W-1:0]     m_nbits_q, m_nbits_d;
  logic                 m_tlast_q, m_tlast_d;
  logic                 m_low_conf_q, m_low_conf_d;
  logic                 m_tvalid_q, m_tvalid_d;

  // Decision datapath, all at WIDTH+1 bits so the extreme negative values are exact.
  logic [WIDTH:0]       i_ext, q_ext, sum, sum_abs, i_abs, q_abs, q_min, metric;
  logic                 sym_mode, low, accept, do_flush, full, emit;
  logic [1:0]           sym_bits;
  logic [CNT_W-1:0]     step, fill_n;
  logic [OUT_WIDTH-1:0] ins, acc_n;

  assign s_tready = !rst && (!m_tvalid_q || m_tready);

  always_comb begin
    i_ext   = {s_i_tdata[WIDTH-1], s_i_tdata};
    q_ext   = {s_q_tdata[WIDTH-1], s_q_tdata};
    sum     = i_ext + q_ext;
    // Unsigned magnitudes: negating 100..0 yields 100..0, read as 2^WIDTH.
    sum_abs = sum[WIDTH]   ? (~sum + 1'b1)   : sum;
    i_abs   = i_ext[WIDTH] ? (~i_ext + 1'b1) : i_ext;
    q_abs   = q_ext[WIDTH] ? (~q_ext + 1'b1) : q_ext;
    q_min   = (i_abs < q_abs) ? i_abs : q_abs;

    // A word's first symbol uses the live mode; later symbols use the latched one.
    sym_mode = (state_q == EMPTY) ? mode : mode_q;
    metric   = sym_mode ? q_min : sum_abs;
    low      = metric < {1'b0, thresh};
    sym_bits = sym_mode ? {s_i_tdata[WIDTH-1], s_q_tdata[WIDTH-1]} : {sum[WIDTH], 1'b0};
    step     = sym_mode ? CNT_W'(2) : CNT_W'(1);

    accept   = s_tvalid && s_tready;
    // Place the symbol's bits just below those already filled.
    ins      = (OUT_WIDTH'(sym_bits) << (OUT_WIDTH - 2)) >> fill_q;
    acc_n    = accept ? (acc_q | ins) : acc_q;
    fill_n   = accept ? (fill_q + step) : fill_q;
    full     = accept && (fill_n == CNT_W'(OUT_WIDTH));
    do_flush = flush && s_tready && ((fill_q != '0) || accept);
    emit     = full || do_flush;

    state_d      = state_q;
    fill_d       = fill_n;
    acc_d        = acc_n;
    sticky_d     = sticky_q || (accept && low);
    mode_d       = mode_q;
    m_tdata_d    = m_tdata_q;
    m_nbits_d    = m_nbits_q;
    m_tlast_d    = m_tlast_q;
    m_low_conf_d = m_low_conf_q;
    m_tvalid_d   = m_tvalid_q && !m_tready;

    case (state_q)
      EMPTY: begin
        if (accept) begin
          mode_d  = mode;
          state_d = PARTIAL;
        end
      end
      PARTIAL: ;
      default: state_d = EMPTY;
    endcase

    // Emission only happens while s_tready=1, so the output slot is free.
    if (emit) begin
      m_tdata_d    = acc_n;
      m_nbits_d    = fill_n;
      m_tlast_d    = do_flush;
      m_low_conf_d = sticky_q || (accept && low);
      m_tvalid_d   = 1'b1;
      acc_d        = '0;
      fill_d       = '0;
      sticky_d     = 1'b0;
      state_d      = EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= EMPTY;
      fill_q       <= '0;
      acc_q        <= '0;
      sticky_q     <= 1'b0;
      mode_q       <= 1'b0;
      m_tdata_q    <= '0;
      m_nbits_q    <= '0;
      m_tlast_q    <= 1'b0;
      m_low_conf_q <= 1'b0;
      m_tvalid_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      fill_q       <= fill_d;
      acc_q        <= acc_d;
      sticky_q     <= sticky_d;
      mode_q       <= mode_d;
      m_tdata_q    <= m_tdata_d;
      m_nbits_q    <= m_nbits_d;
      m_tlast_q    <= m_tlast_d;
      m_low_conf_q <= m_low_conf_d;
      m_tvalid_q   <= m_tvalid_d;
    end
  end

  assign m_tdata    = m_tdata_q;
  assign m_nbits    = m_nbits_q;
  assign m_tlast    = m_tlast_q;
  assign m_low_conf = m_low_conf_q;
  assign m_tvalid   = m_tvalid_q;

endmodule

// File: tb/tb_psk_demod_packer.sv
// tb/tb_psk_demod_packer.sv - directed vector bench for psk_demod_packer
module tb_psk_demod_packer;

  localparam int W  = 16;
  localparam int OW = 8;
  localparam int CW = $clog2(OW + 1);

  logic          clk = 1'b0;
  logic          rst, mode, flush, s_tvalid, s_tready, m_tready;
  logic [W-1:0]  thresh, s_i_tdata, s_q_tdata;
  logic [OW-1:0] m_tdata;
  logic [CW-1:0] m_nbits;
  logic          m_tlast, m_low_conf, m_tvalid;

  int n_vec  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  psk_demod_packer #(.WIDTH(W), .OUT_WIDTH(OW)) dut (
    .clk(clk), .rst(rst), .mode(mode), .thresh(thresh), .flush(flush),
    .s_i_tdata(s_i_tdata), .s_q_tdata(s_q_tdata), .s_tvalid(s_tvalid),
    .s_tready(s_tready), .m_tdata(m_tdata), .m_nbits(m_nbits),
    .m_tlast(m_tlast), .m_low_conf(m_low_conf), .m_tvalid(m_tvalid),
    .m_tready(m_tready)
  );

  typedef struct {
    logic             md;
    logic [W-1:0]     thr;
    int               nsym;
    logic [7:0][W-1:0] iv;
    logic [7:0][W-1:0] qv;
    logic [OW-1:0]    exp_data;
    logic             exp_low;
  } vec_t;

  vec_t vt[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Present one symbol for one edge, then release.
  task automatic sym(input logic md, input logic [W-1:0] i, input logic [W-1:0] q, input logic fl);
    mode = md; s_i_tdata = i; s_q_tdata = q; s_tvalid = 1'b1; flush = fl;
    @(posedge clk); #1;
    s_tvalid = 1'b0; flush = 1'b0;
  endtask

  task automatic setv(input int n, input logic md, input logic [W-1:0] thr, input int ns,
                      input logic [OW-1:0] d, input logic lo);
    vt[n].md = md; vt[n].thr = thr; vt[n].nsym = ns; vt[n].exp_data = d; vt[n].exp_low = lo;
    vt[n].iv = '0; vt[n].qv = '0;
  endtask

  task automatic chk_word(input string name, input logic [OW-1:0] d, input int nb,
                          input logic tl, input logic lo);
    chk({name, ".tvalid"}, 32'(m_tvalid), 32'd1);
    chk({name, ".tdata"}, 32'(m_tdata), 32'(d));
    chk({name, ".nbits"}, 32'(m_nbits), 32'(nb));
    chk({name, ".tlast"}, 32'(m_tlast), 32'(tl));
    chk({name, ".low_conf"}, 32'(m_low_conf), 32'(lo));
  endtask

  initial begin
    rst = 1'b1; mode = 1'b0; flush = 1'b0; s_tvalid = 1'b0; m_tready = 1'b1;
    thresh = '0; s_i_tdata = '0; s_q_tdata = '0;

    setv(0, 1'b0, 16'd50, 8, 8'hAA, 1'b0);
    for (int k = 0; k < 8; k++) vt[0].iv[k] = (k % 2 == 0) ? 16'(-100) : 16'(100);
    setv(1, 1'b1, 16'd0, 4, 8'h1B, 1'b0);
    vt[1].iv[0] = 16'(5);  vt[1].qv[0] = 16'(5);
    vt[1].iv[1] = 16'(5);  vt[1].qv[1] = 16'(-5);
    vt[1].iv[2] = 16'(-5); vt[1].qv[2] = 16'(5);
    vt[1].iv[3] = 16'(-5); vt[1].qv[3] = 16'(-5);
    setv(2, 1'b0, 16'd1, 8, 8'h40, 1'b1);
    vt[2].iv[0] = 16'(300); vt[2].qv[0] = 16'(-300);
    vt[2].iv[1] = 16'h8000; vt[2].qv[1] = 16'h8000;
    for (int k = 2; k < 8; k++) vt[2].iv[k] = 16'(10);
    setv(3, 1'b1, 16'd10, 4, 8'h80, 1'b1);
    vt[3].iv[0] = 16'h8000; vt[3].qv[0] = 16'(7);
    for (int k = 1; k < 4; k++) begin vt[3].iv[k] = 16'(1000); vt[3].qv[k] = 16'(1000); end
    setv(4, 1'b0, 16'd200, 8, 8'h00, 1'b0);
    for (int k = 0; k < 8; k++) begin vt[4].iv[k] = 16'(150); vt[4].qv[k] = 16'(50); end
    setv(5, 1'b0, 16'd0, 8, 8'hFF, 1'b0);
    for (int k = 0; k < 8; k++) vt[5].iv[k] = 16'(-1);
    setv(6, 1'b1, 16'h8000, 4, 8'hFF, 1'b0);
    for (int k = 0; k < 4; k++) begin vt[6].iv[k] = 16'h8000; vt[6].qv[k] = 16'h8000; end
    setv(7, 1'b1, 16'h8001, 4, 8'hFF, 1'b1);
    for (int k = 0; k < 4; k++) begin vt[7].iv[k] = 16'h8000; vt[7].qv[k] = 16'h8000; end

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.s_tready", 32'(s_tready), 32'd0);
    chk("rst.tvalid", 32'(m_tvalid), 32'd0);
    chk("rst.tdata", 32'(m_tdata), 32'd0);
    chk("rst.nbits", 32'(m_nbits), 32'd0);
    chk("rst.tlast", 32'(m_tlast), 32'd0);
    chk("rst.low_conf", 32'(m_low_conf), 32'd0);
    rst = 1'b0; #1;
    chk("idle.s_tready", 32'(s_tready), 32'd1);

    // Full-word vector table
    for (int n = 0; n < 8; n++) begin
      thresh = vt[n].thr;
      for (int k = 0; k < vt[n].nsym; k++) begin
        if (k == vt[n].nsym - 1) chk($sformatf("vec%0d.pending", n), 32'(m_tvalid && n > 0 ? 0 : m_tvalid), 32'd0);
        sym(vt[n].md, vt[n].iv[k], vt[n].qv[k], 1'b0);
      end
      chk_word($sformatf("vec%0d", n), vt[n].exp_data, OW, 1'b0, vt[n].exp_low);
    end
    @(posedge clk); #1;
    chk("drain.tvalid", 32'(m_tvalid), 32'd0);

    // Backpressure: word held stable, no input accepted
    m_tready = 1'b0; thresh = 16'd50;
    for (int k = 0; k < 8; k++) sym(1'b0, vt[0].iv[k], 16'd0, 1'b0);
    chk_word("bp", 8'hAA, OW, 1'b0, 1'b0);
    for (int c = 0; c < 10; c++) begin
      s_tvalid = 1'b1; s_i_tdata = 16'(-7);
      @(posedge clk); #1;
      chk($sformatf("bp.hold%0d.s_tready", c), 32'(s_tready), 32'd0);
      chk($sformatf("bp.hold%0d.tdata", c), 32'({m_tvalid, m_tdata}), 32'h1AA);
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1; #1;
    chk("bp.release.s_tready", 32'(s_tready), 32'd1);
    @(posedge clk); #1;
    chk("bp.release.tvalid", 32'(m_tvalid), 32'd0);

    // Flush of a partial QPSK word, then a flush with nothing buffered
    thresh = 16'd0;
    sym(1'b1, 16'(-5), 16'(-5), 1'b0);
    sym(1'b1, 16'(5), 16'(5), 1'b0);
    sym(1'b1, 16'(5), 16'(-5), 1'b0);
    chk("fl.early.tvalid", 32'(m_tvalid), 32'd0);
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    chk_word("fl.partial", 8'hC4, 6, 1'b1, 1'b0);
    @(posedge clk); #1;
    flush = 1'b1; @(posedge clk); #1; flush = 1'b0;
    chk("fl.empty.tvalid", 32'(m_tvalid), 32'd0);

    // Flush together with the symbol that completes a word
    for (int k = 0; k < 7; k++) sym(1'b0, 16'(-1), 16'd0, 1'b0);
    sym(1'b0, 16'(10), 16'd0, 1'b1);
    chk_word("fl.full", 8'hFE, OW, 1'b1, 1'b0);
    // Flush together with the first symbol of a word
    sym(1'b0, 16'(-1), 16'd0, 1'b1);
    chk_word("fl.single", 8'h80, 1, 1'b1, 1'b0);
    @(posedge clk); #1;

    // Mode change mid-word is ignored
    sym(1'b1, 16'(-5), 16'(-5), 1'b0);
    sym(1'b0, 16'(5), 16'(-5), 1'b0);
    sym(1'b0, 16'(-5), 16'(5), 1'b0);
    chk("mode.early.tvalid", 32'(m_tvalid), 32'd0);
    sym(1'b0, 16'(5), 16'(5), 1'b0);
    chk_word("mode", 8'hD8, OW, 1'b0, 1'b0);

    // Reset mid-word discards the partial word
    sym(1'b1, 16'(-5), 16'(-5), 1'b0);
    sym(1'b1, 16'(-5), 16'(-5), 1'b0);
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
    chk("rstmid.tvalid", 32'(m_tvalid), 32'd0);
    sym(1'b1, 16'(-5), 16'(5), 1'b0);
    sym(1'b1, 16'(-5), 16'(5), 1'b0);
    chk("rstmid.half.tvalid", 32'(m_tvalid), 32'd0);
    sym(1'b1, 16'(-5), 16'(5), 1'b0);
    sym(1'b1, 16'(-5), 16'(5), 1'b0);
    chk_word("rstmid.word", 8'hAA, OW, 1'b0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
